// File: rtl/display_banco_7seg_if.sv
// display_banco_7seg_if
//   Groups the register-bank read/write signals consumed by the display
//   driver together with the multiplexed display outputs it produces.
//   Signals:
//     addrRa, datOutRa  - bank read port A address (3b) / data (4b)
//     addrRb, datOutRb  - bank read port B address (3b) / data (4b)
//     RegWrite          - bank write enable (shown on decimal points)
//     sseg              - segments {g,f,e,d,c,b,a}, active-low
//     dp                - decimal point, active-low
//     an                - digit anodes, active-low one-hot
//     digit             - index of the digit currently driven
//   Modports:
//     master - bank side / observer: drives bank signals, reads display
//     slave  - display driver: reads bank signals, drives display
interface display_banco_7seg_if;
    logic [2:0] addrRa;
    logic [3:0] datOutRa;
    logic [2:0] addrRb;
    logic [3:0] datOutRb;
    logic       RegWrite;
    logic [6:0] sseg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] digit;

    modport master (
        output addrRa, datOutRa, addrRb, datOutRb, RegWrite,
        input  sseg, dp, an, digit
    );

    modport slave (
        input  addrRa, datOutRa, addrRb, datOutRb, RegWrite,
        output sseg, dp, an, digit
    );
endinterface

// File: rtl/display_banco_7seg.sv
// display_banco_7seg
//   Multiplexed 4-digit seven-segment driver for the 8x4 register bank.
//   Each frame (4*REFRESH_DIV cycles) shows, in hex:
//     digit0 = datOutRb, digit1 = addrRb, digit2 = datOutRa, digit3 = addrRa
//   Bank inputs are snapshotted once per frame so digits never tear.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset (blanks the display)
//     bus  - display_banco_7seg_if.slave (bank inputs, display outputs)
//   Parameter:
//     REFRESH_DIV - cycles each digit stays lit (>= 1)
module display_banco_7seg #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    display_banco_7seg_if.slave  bus
);

    localparam int              CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    logic [CW-1:0] cnt_q, cnt_d;
    slot_e         slot_q, slot_d;

    logic [2:0]    ra_q, ra_d;
    logic [3:0]    da_q, da_d;
    logic [2:0]    rb_q, rb_d;
    logic [3:0]    db_q, db_d;
    logic          rw_q, rw_d;

    logic [3:0]    an_q, an_d;
    logic [6:0]    sseg_q, sseg_d;
    logic          dp_q, dp_d;
    logic [1:0]    digit_q, digit_d;

    logic          wrap;
    logic          capture;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap    = (cnt_q == CNT_MAX);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        slot_d  = slot_q;
        if (wrap) begin
            case (slot_q)
                SLOT0:   slot_d = SLOT1;
                SLOT1:   slot_d = SLOT2;
                SLOT2:   slot_d = SLOT3;
                SLOT3:   slot_d = SLOT0;
                default: slot_d = SLOT0;
            endcase
        end

        // Snapshot at end of frame; the new frame's slot0 already sees it.
        capture = wrap && (slot_q == SLOT3);
        ra_d = capture ? bus.addrRa   : ra_q;
        da_d = capture ? bus.datOutRa : da_q;
        rb_d = capture ? bus.addrRb   : rb_q;
        db_d = capture ? bus.datOutRb : db_q;
        rw_d = capture ? bus.RegWrite : rw_q;

        nibble = '0;
        an_d   = '1;
        dp_d   = 1'b1;
        case (slot_q)
            SLOT0: begin an_d = 4'b1110; nibble = db_q;         end
            SLOT1: begin an_d = 4'b1101; nibble = {1'b0, rb_q}; dp_d = ~rw_q; end
            SLOT2: begin an_d = 4'b1011; nibble = da_q;         end
            SLOT3: begin an_d = 4'b0111; nibble = {1'b0, ra_q}; dp_d = ~rw_q; end
            default: begin an_d = '1; nibble = '0; end
        endcase
        sseg_d  = hex7(nibble);
        digit_d = slot_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= SLOT0;
            ra_q    <= '0;
            da_q    <= '0;
            rb_q    <= '0;
            db_q    <= '0;
            rw_q    <= 1'b0;
            an_q    <= '1;
            sseg_q  <= '1;
            dp_q    <= 1'b1;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            ra_q    <= ra_d;
            da_q    <= da_d;
            rb_q    <= rb_d;
            db_q    <= db_d;
            rw_q    <= rw_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            dp_q    <= dp_d;
            digit_q <= digit_d;
        end
    end

    assign bus.an    = an_q;
    assign bus.sseg  = sseg_q;
    assign bus.dp    = dp_q;
    assign bus.digit = digit_q;

endmodule

// File: tb/tb_display_banco_7seg.sv
// Testbench for display_banco_7seg: two instances (REFRESH_DIV=4 and 1)
// share clock and reset; a frame/slot model derived from the edge count
// since reset predicts every output on every cycle.
module tb_display_banco_7seg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_banco_7seg_if b0 ();
    display_banco_7seg_if b1 ();

    display_banco_7seg #(.REFRESH_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    display_banco_7seg #(.REFRESH_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model state per instance
    int unsigned div [2] = '{4, 1};
    int unsigned e   [2];            // edges since reset release
    logic [2:0]  s_ra [2];
    logic [3:0]  s_da [2];
    logic [2:0]  s_rb [2];
    logic [3:0]  s_db [2];
    logic        s_rw [2];
    logic [3:0]  x_an [2];
    logic [6:0]  x_sg [2];
    logic        x_dp [2];
    logic [1:0]  x_dg [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic [2:0] ra [2];
        logic [3:0] da [2];
        logic [2:0] rb [2];
        logic [3:0] db [2];
        logic       rw [2];
        int unsigned slot, val;
        ra[0] = b0.addrRa; da[0] = b0.datOutRa; rb[0] = b0.addrRb; db[0] = b0.datOutRb; rw[0] = b0.RegWrite;
        ra[1] = b1.addrRa; da[1] = b1.datOutRa; rb[1] = b1.addrRb; db[1] = b1.datOutRb; rw[1] = b1.RegWrite;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                x_an[i] = 4'hF; x_sg[i] = 7'h7F; x_dp[i] = 1'b1; x_dg[i] = 2'd0;
                e[i] = 0;
                s_ra[i] = '0; s_da[i] = '0; s_rb[i] = '0; s_db[i] = '0; s_rw[i] = 1'b0;
            end else begin
                slot = (e[i] / div[i]) % 4;
                case (slot)
                    0: val = s_db[i];
                    1: val = s_rb[i];
                    2: val = s_da[i];
                    default: val = s_ra[i];
                endcase
                x_sg[i] = HEX[val];
                x_an[i] = ~(4'b0001 << slot);
                x_dp[i] = !((slot % 2 == 1) && s_rw[i]);
                x_dg[i] = 2'(slot);
                if (e[i] % (4 * div[i]) == 4 * div[i] - 1) begin
                    s_ra[i] = ra[i]; s_da[i] = da[i]; s_rb[i] = rb[i]; s_db[i] = db[i]; s_rw[i] = rw[i];
                end
                e[i]++;
            end
        end
        #1;
        chk("an0",    {4'h0, b0.an},    {4'h0, x_an[0]});
        chk("sseg0",  {1'b0, b0.sseg},  {1'b0, x_sg[0]});
        chk("dp0",    {7'h0, b0.dp},    {7'h0, x_dp[0]});
        chk("digit0", {6'h0, b0.digit}, {6'h0, x_dg[0]});
        chk("an1",    {4'h0, b1.an},    {4'h0, x_an[1]});
        chk("sseg1",  {1'b0, b1.sseg},  {1'b0, x_sg[1]});
        chk("dp1",    {7'h0, b1.dp},    {7'h0, x_dp[1]});
        chk("digit1", {6'h0, b1.digit}, {6'h0, x_dg[1]});
    endtask

    task automatic run_to(input int unsigned n);
        int unsigned guard = 0;
        while (e[0] != n && guard < 200) begin step(); guard++; end
        chk("run_to", {7'h0, (e[0] == n)}, 8'h01);
    endtask

    task automatic run_mod(input int unsigned m);
        int unsigned guard = 0;
        while (e[0] % 16 != m && guard < 40) begin step(); guard++; end
        chk("run_mod", {7'h0, (e[0] % 16 == m)}, 8'h01);
    endtask

    initial begin
        rst = 1'b1;
        b0.addrRa = 3'd2; b0.datOutRa = 4'h5; b0.addrRb = 3'd6; b0.datOutRb = 4'hA; b0.RegWrite = 1'b0;
        b1.addrRa = 3'd0; b1.datOutRa = 4'h8; b1.addrRb = 3'd1; b1.datOutRb = 4'hF; b1.RegWrite = 1'b0;
        e[0] = 0; e[1] = 0;

        // Reset held for three cycles: display blank
        repeat (3) step();
        rst = 1'b0;

        // Frame 1 zeros, frame 2 shows held data; change inputs at slot1 cnt=2
        run_to(22);
        b0.datOutRb = 4'h3;
        b0.addrRa   = 3'd7;

        // Frame 3 shows new data; write indicator captured at frame end
        run_mod(15);
        b0.RegWrite = 1'b1;
        step();
        b0.RegWrite = 1'b0;

        // RegWrite pulsed mid-frame only: next frame has no dp
        run_mod(5);
        b0.RegWrite = 1'b1;
        step();
        b0.RegWrite = 1'b0;
        run_mod(0);
        repeat (16) step();

        // Randomized inputs on both instances
        for (int k = 0; k < 200; k++) begin
            b0.addrRa = 3'($urandom); b0.datOutRa = 4'($urandom);
            b0.addrRb = 3'($urandom); b0.datOutRb = 4'($urandom);
            b0.RegWrite = 1'($urandom);
            b1.addrRa = 3'($urandom); b1.datOutRa = 4'($urandom);
            b1.addrRb = 3'($urandom); b1.datOutRb = 4'($urandom);
            b1.RegWrite = 1'($urandom);
            step();
        end

        // Reset for one cycle at slot2 cnt=1
        run_mod(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
